debug_writer: RTL and testbench

Board-side debug entry block that lets the operator type a 32-bit value in hex on the switches and write it into the MIPS core's register file or data memory. It is the write-direction counterpart of the seven-segment debug readout: push-buttons are debounced, nibbles are shifted into a staging register, and a commit issues a single request/acknowledge write transaction toward the core's debug write port. It sits in the board top level next to the display and clock divider and runs on the board clock.

---
 rtl/debug_writer_if.sv | 24 ++
 rtl/debug_writer.sv | 150 +++++++++++++++
 tb/tb_debug_writer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/debug_writer_if.sv
// rtl/debug_writer_if.sv - debug write handshake toward the core's debug write port
interface debug_writer_if;
   logic        wr_req;
   logic        wr_ack;
   logic        wr_mem;
   logic [5:0]  wr_addr;
   logic [31:0] wr_data;

   modport master (
      output wr_req,
      output wr_mem,
      output wr_addr,
      output wr_data,
      input  wr_ack
   );

   modport slave (
      input  wr_req,
      input  wr_mem,
      input  wr_addr,
      input  wr_data,
      output wr_ack
   );
endinterface

// File: rtl/debug_writer.sv
// rtl/debug_writer.sv - switch/button hex entry that issues one debug write (optional DEBUG_WRITER_TIMEOUT_EN)
module debug_writer #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input  logic                CLK100MHZ,
   input  logic                CPU_RESETN,
   input  logic [3:0]          nibble,
   input  logic                target_sel,
   input  logic [5:0]          target_addr,
   input  logic                btn_shift,
   input  logic                btn_commit,
   input  logic                btn_clear,
   debug_writer_if.master      wr,
   output logic [31:0]         staged,
   output logic                busy,
   output logic                err,
   output logic [7:0]          wr_count
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

   // index 0 = shift, 1 = commit, 2 = clear
   logic [2:0]    raw;
   logic [2:0]    sync0_q, sync1_q, stable_q, prev_q;
   logic [CW-1:0] cnt_q [3];
   logic [2:0]    pulse;

   state_t        state_q;
   logic          req_q, mem_q, err_q;
   logic [5:0]    addr_q;
   logic [31:0]   data_q;
   logic [7:0]    count_q;
   logic [31:0]   staged_q, staged_d;

   assign raw   = {btn_clear, btn_commit, btn_shift};
   assign pulse = stable_q & ~prev_q;

   // Synchronise each button, then accept a new level only after it has held for DEBOUNCE_CYCLES
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         sync0_q  <= '0;
         sync1_q  <= '0;
         stable_q <= '0;
         prev_q   <= '0;
         for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      end else begin
         sync0_q <= raw;
         sync1_q <= sync0_q;
         prev_q  <= stable_q;
         for (int i = 0; i < 3; i++) begin
            if (sync1_q[i] == stable_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
               stable_q[i] <= sync1_q[i];
               cnt_q[i]    <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + CW'(1);
            end
         end
      end
   end

   // Staging register next value: clear has priority over shift
   always_comb begin
      staged_d = staged_q;
      if (pulse[2])      staged_d = '0;
      else if (pulse[0]) staged_d = {staged_q[27:0], nibble};
   end

   // Staging register update
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) staged_q <= '0;
      else             staged_q <= staged_d;
   end

`ifdef DEBUG_WRITER_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TW-1:0] tmo_q;
`endif

   // Write transaction FSM with registered request, latched target and sticky error
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         mem_q   <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         count_q <= '0;
`ifdef DEBUG_WRITER_TIMEOUT_EN
         tmo_q   <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (pulse[1]) begin
                  // r0 is hardwired zero in the core, so writing it is flagged instead of issued
                  if (!target_sel && target_addr[4:0] == 5'd0) begin
                     err_q <= 1'b1;
                  end else begin
                     mem_q   <= target_sel;
                     addr_q  <= target_addr;
                     data_q  <= staged_q;
                     req_q   <= 1'b1;
                     state_q <= REQ;
`ifdef DEBUG_WRITER_TIMEOUT_EN
                     tmo_q   <= '0;
`endif
                  end
               end
            end
            REQ: begin
               if (wr.wr_ack) begin
                  req_q   <= 1'b0;
                  state_q <= IDLE;
                  count_q <= count_q + 8'd1;
               end
`ifdef DEBUG_WRITER_TIMEOUT_EN
               else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                  req_q   <= 1'b0;
                  state_q <= IDLE;
                  err_q   <= 1'b1;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
`endif
            end
            default: begin
               req_q   <= 1'b0;
               state_q <= IDLE;
            end
         endcase
         if (pulse[2]) err_q <= 1'b0;
      end
   end

   assign wr.wr_req  = req_q;
   assign wr.wr_mem  = mem_q;
   assign wr.wr_addr = addr_q;
   assign wr.wr_data = data_q;
   assign busy       = req_q;
   assign err        = err_q;
   assign wr_count   = count_q;
   assign staged     = staged_q;

endmodule

// File: tb/tb_debug_writer.sv
// tb/tb_debug_writer.sv - directed self-checking bench for debug_writer
module tb_debug_writer;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  nibble;
   logic        target_sel;
   logic [5:0]  target_addr;
   logic        btn_shift, btn_commit, btn_clear;
   logic [31:0] staged;
   logic        busy, err;
   logic [7:0]  wr_count;

   always #5 clk = ~clk;

   debug_writer_if ifc();

   debug_writer #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(8)) dut (
      .CLK100MHZ   (clk),
      .CPU_RESETN  (rst_n),
      .nibble      (nibble),
      .target_sel  (target_sel),
      .target_addr (target_addr),
      .btn_shift   (btn_shift),
      .btn_commit  (btn_commit),
      .btn_clear   (btn_clear),
      .wr          (ifc),
      .staged      (staged),
      .busy        (busy),
      .err         (err),
      .wr_count    (wr_count)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // core model: ack once wr_req has been seen for ack_after cycles (0 = never)
   int   ack_after = 0;
   int   hold      = 0;
   int   req_total = 0;
   int   txn       = 0;
   logic prev_req  = 1'b0;

   always @(negedge clk) begin
      if (ifc.wr_req === 1'b1) begin
         if (!prev_req) txn++;
         hold++;
         req_total++;
         ifc.wr_ack = (ack_after != 0 && hold >= ack_after);
      end else begin
         hold = 0;
         ifc.wr_ack = 1'b0;
      end
      prev_req = (ifc.wr_req === 1'b1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_btn(input int b, input logic v);
      case (b)
         0: btn_shift  = v;
         1: btn_commit = v;
         default: btn_clear = v;
      endcase
   endtask

   task automatic press(input int b);
      set_btn(b, 1'b1);
      repeat (10) tick();
      set_btn(b, 1'b0);
      repeat (10) tick();
   endtask

   task automatic shift_nib(input logic [3:0] n);
      nibble = n;
      press(0);
   endtask

   int txn0;
   int waited;
   logic [31:0] deadbeef;

   initial begin
      ifc.wr_ack  = 1'b0;
      rst_n       = 1'b0;
      nibble      = 4'h0;
      target_sel  = 1'b0;
      target_addr = 6'd0;
      btn_shift   = 1'b0;
      btn_commit  = 1'b0;
      btn_clear   = 1'b0;
      repeat (3) tick();
      check("rst_staged",  staged, 32'h0);
      check("rst_wr_req",  {31'b0, ifc.wr_req}, 32'h0);
      check("rst_busy",    {31'b0, busy}, 32'h0);
      check("rst_err",     {31'b0, err}, 32'h0);
      check("rst_count",   {24'b0, wr_count}, 32'h0);
      check("rst_wr_data", ifc.wr_data, 32'h0);
      check("rst_wr_addr", {26'b0, ifc.wr_addr}, 32'h0);
      rst_n = 1'b1;
      tick();

      // shift 1..8
      for (int i = 1; i <= 8; i++) shift_nib(4'(i));
      check("shift_12345678", staged, 32'h12345678);

      // 2-cycle glitches rejected
      for (int g = 0; g < 3; g++) begin
         btn_shift = 1'b1;
         repeat (2) tick();
         btn_shift = 1'b0;
         repeat (8) tick();
      end
      check("glitch_no_change", staged, 32'h12345678);

      // load DEADBEEF and write register 5 with ack after 3 cycles
      press(2);
      deadbeef = 32'hDEADBEEF;
      for (int i = 7; i >= 0; i--) shift_nib(deadbeef[i*4 +: 4]);
      check("staged_deadbeef", staged, 32'hDEADBEEF);
      target_sel  = 1'b0;
      target_addr = 6'd5;
      ack_after   = 3;
      req_total   = 0;
      press(1);
      check("w1_req_cycles", req_total, 32'd3);
      check("w1_addr",  {26'b0, ifc.wr_addr}, 32'd5);
      check("w1_data",  ifc.wr_data, 32'hDEADBEEF);
      check("w1_mem",   {31'b0, ifc.wr_mem}, 32'd0);
      check("w1_count", {24'b0, wr_count}, 32'd1);
      check("w1_busy",  {31'b0, busy}, 32'd0);

      // r0 through addr 0x20 is refused
      target_addr = 6'h20;
      txn0 = txn;
      press(1);
      check("r0_no_txn", txn - txn0, 32'd0);
      check("r0_err",    {31'b0, err}, 32'd1);
      check("r0_count",  {24'b0, wr_count}, 32'd1);
      press(2);
      check("clr_err",    {31'b0, err}, 32'd0);
      check("clr_staged", staged, 32'h0);

      // commit and shift while a write is pending
      shift_nib(4'h1);
      shift_nib(4'h2);
      target_sel  = 1'b1;
      target_addr = 6'd7;
      ack_after   = 0;
      txn0 = txn;
      press(1);
      check("req_busy", {31'b0, busy}, 32'd1);
      press(1);
      shift_nib(4'hA);
      check("req_staged", staged, 32'h0000012A);
      check("req_data",   ifc.wr_data, 32'h00000012);
      check("req_mem",    {31'b0, ifc.wr_mem}, 32'd1);
      check("req_addr",   {26'b0, ifc.wr_addr}, 32'd7);
      check("req_err",    {31'b0, err}, 32'd0);
`ifndef DEBUG_WRITER_TIMEOUT_EN
      check("req_still_busy", {31'b0, busy}, 32'd1);
      ack_after = 1;
      repeat (3) tick();
      check("req_count", {24'b0, wr_count}, 32'd2);
`endif
      check("req_single_txn", txn - txn0, 32'd1);
      check("req_done_busy", {31'b0, busy}, 32'd0);

      // reset in the middle of a request
      ack_after  = 0;
      btn_commit = 1'b1;
      waited = 0;
      while (ifc.wr_req !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      check("rstmid_req_seen", {31'b0, ifc.wr_req}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("rstmid_req",    {31'b0, ifc.wr_req}, 32'd0);
      check("rstmid_busy",   {31'b0, busy}, 32'd0);
      check("rstmid_count",  {24'b0, wr_count}, 32'd0);
      check("rstmid_data",   ifc.wr_data, 32'h0);
      check("rstmid_staged", staged, 32'h0);
      btn_commit = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (12) tick();
      check("rstmid_no_replay", {31'b0, ifc.wr_req}, 32'd0);

      // wr_count wraps 255 -> 0
      ack_after  = 1;
      target_sel = 1'b1;
      for (int i = 0; i < 255; i++) press(1);
      check("count_255", {24'b0, wr_count}, 32'd255);
      press(1);
      check("count_wrap", {24'b0, wr_count}, 32'd0);

`ifdef DEBUG_WRITER_TIMEOUT_EN
      // never ack: request abandoned after 8 cycles
      ack_after = 0;
      req_total = 0;
      press(1);
      repeat (10) tick();
      check("tmo_req_cycles", req_total, 32'd8);
      check("tmo_busy",  {31'b0, busy}, 32'd0);
      check("tmo_err",   {31'b0, err}, 32'd1);
      check("tmo_count", {24'b0, wr_count}, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
